planificador_cubos: RTL and testbench

//  Game-level spawn scheduler for the falling-cubes datapath. Generates the 5-column

---
 rtl/planificador_cubos_pkg.sv | 31 +++
 rtl/planificador_cubos_lfsr.sv | 35 +++
 rtl/planificador_cubos.sv | 177 +++++++++++++++++
 tb/tb_planificador_cubos.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/planificador_cubos_pkg.sv
// Shared definitions for the falling-cubes spawn scheduler.
//   estado_t        : scheduler FSM state encoding (3-bit)
//   N_COLUMNAS      : number of cube columns in a spawn pattern
//   PATRON_*_SUST   : replacements for the all-empty / all-full raw patterns
//   LFSR_TAPS       : Galois tap mask for x^16 + x^14 + x^13 + x^11 + 1
//   patron()        : maps raw LFSR bits to a legal spawn pattern
package planificador_cubos_pkg;

  typedef enum logic [2:0] {
    REPOSO  = 3'd0,
    ESPERA  = 3'd1,
    EMITE   = 3'd2,
    PAUSADO = 3'd3,
    FIN     = 3'd4
  } estado_t;

  localparam int               N_COLUMNAS        = 5;
  localparam logic [N_COLUMNAS-1:0] PATRON_VACIO_SUST = 5'b00100;
  localparam logic [N_COLUMNAS-1:0] PATRON_LLENO_SUST = 5'b11011;
  localparam logic [15:0]      LFSR_TAPS         = 16'hB400;

  // Every spawn must contain at least one cube and at least one gap.
  function automatic logic [N_COLUMNAS-1:0] patron(input logic [N_COLUMNAS-1:0] crudo);
    logic [N_COLUMNAS-1:0] res;
    res = crudo;
    if (crudo == '0) res = PATRON_VACIO_SUST;
    else if (crudo == '1) res = PATRON_LLENO_SUST;
    return res;
  endfunction

endpackage

// File: rtl/planificador_cubos_lfsr.sv
// lfsr_cubos: 16-bit Galois LFSR feeding the spawn pattern generator.
//   clk     in   system clock
//   reset   in   synchronous active-high reset, loads semilla
//   avanzar in   advance one step this cycle
//   semilla in   reset seed (must be non-zero)
//   valor   out  current LFSR contents
module lfsr_cubos
  import planificador_cubos_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        avanzar,
  input  logic [15:0] semilla,
  output logic [15:0] valor
);

  logic [15:0] valor_q;
  logic [15:0] valor_d;

  // Right-shifting Galois form: the bit shifted out toggles the tap positions.
  always_comb begin
    valor_d = valor_q;
    if (avanzar) begin
      valor_d = (valor_q >> 1) ^ (valor_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) valor_q <= semilla;
    else       valor_q <= valor_d;
  end

  assign valor = valor_q;

endmodule

// File: rtl/planificador_cubos.sv
// planificador_cubos: spawn scheduler for the falling-cubes datapath.
// Counts video frames, emits a one-cycle spawn strobe with a pseudo-random
// 5-column pattern every 'periodo' frames, and shortens the period per level.
//   clk                     in   system clock
//   reset                   in   synchronous active-high reset
//   tick_frame              in   one-cycle strobe per video frame
//   iniciar                 in   start/restart request (REPOSO and FIN only)
//   pausa                   in   pause while high
//   fin_juego               in   game-over indication
//   cubos_entrada           out  registered spawn pattern, bit i = column i
//   pulso_habilitador       out  one-cycle spawn strobe
//   bandera_habilitar_cubos out  high while running (ESPERA/EMITE)
//   nivel                   out  current level, saturates at 7
// Priority inside the running states: fin_juego > pausa > tick_frame.
// All outputs are registered and decoded from the next state, so the strobe
// appears the cycle right after the tick that exhausts the frame counter.
module planificador_cubos
  import planificador_cubos_pkg::*;
#(
  parameter int          PERIODO_INICIAL = 60,
  parameter int          PERIODO_MINIMO  = 15,
  parameter int          PASO_PERIODO    = 5,
  parameter int          CUBOS_POR_NIVEL = 8,
  parameter logic [15:0] SEMILLA         = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_frame,
  input  logic                  iniciar,
  input  logic                  pausa,
  input  logic                  fin_juego,
  output logic [N_COLUMNAS-1:0] cubos_entrada,
  output logic                  pulso_habilitador,
  output logic                  bandera_habilitar_cubos,
  output logic [2:0]            nivel
);

  localparam logic [7:0]        PER_INI = 8'(PERIODO_INICIAL);
  localparam logic [7:0]        PER_MIN = 8'(PERIODO_MINIMO);
  localparam logic [7:0]        CPN     = 8'(CUBOS_POR_NIVEL);
  localparam logic signed [8:0] PASO_S  = 9'(PASO_PERIODO);
  localparam logic signed [8:0] MIN_S   = 9'(PERIODO_MINIMO);

  // estado_q is the observable FSM state for checkers.
  estado_t               estado_q, estado_d;
  logic [7:0]            contador_q, contador_d;
  logic [7:0]            periodo_q, periodo_d;
  logic [7:0]            cuenta_q, cuenta_d;
  logic [2:0]            nivel_q, nivel_d;
  logic [N_COLUMNAS-1:0] cubos_q, cubos_d;
  logic                  pulso_q, pulso_d;
  logic                  bandera_q, bandera_d;
  logic                  avanzar;
  logic [15:0]           lfsr_valor;
  logic                  lfsr_alto_unused;
  logic signed [8:0]     periodo_resta;
  logic [7:0]            periodo_nuevo;
  logic [7:0]            cuenta_sig;

  lfsr_cubos u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .avanzar (avanzar),
    .semilla (SEMILLA),
    .valor   (lfsr_valor)
  );

  // Only the low bits select columns; the rest only feed the shift chain.
  assign lfsr_alto_unused = ^lfsr_valor[15:N_COLUMNAS];

  // Period shrink in 9-bit signed arithmetic so a large step never wraps.
  always_comb begin
    periodo_resta = $signed({1'b0, periodo_q}) - PASO_S;
    periodo_nuevo = (periodo_resta < MIN_S) ? PER_MIN : periodo_resta[7:0];
    cuenta_sig    = cuenta_q + 8'd1;
  end

  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    periodo_d  = periodo_q;
    cuenta_d   = cuenta_q;
    nivel_d    = nivel_q;
    cubos_d    = cubos_q;
    avanzar    = 1'b0;

    case (estado_q)
      REPOSO: begin
        if (iniciar) begin
          estado_d   = ESPERA;
          contador_d = periodo_q;
        end
      end
      ESPERA: begin
        if (fin_juego) begin
          estado_d = FIN;
          cubos_d  = '0;
        end else if (pausa) begin
          estado_d = PAUSADO;
        end else if (tick_frame) begin
          if (contador_q <= 8'd1) begin
            estado_d = EMITE;
            avanzar  = 1'b1;
            cubos_d  = patron(lfsr_valor[N_COLUMNAS-1:0]);
          end else begin
            contador_d = contador_q - 8'd1;
          end
        end
      end
      EMITE: begin
        // The emission always completes; inputs are honoured from ESPERA.
        estado_d = ESPERA;
        if (cuenta_sig >= CPN) begin
          cuenta_d   = 8'd0;
          nivel_d    = (nivel_q == 3'd7) ? 3'd7 : nivel_q + 3'd1;
          periodo_d  = periodo_nuevo;
          contador_d = periodo_nuevo;
        end else begin
          cuenta_d   = cuenta_sig;
          contador_d = periodo_q;
        end
      end
      PAUSADO: begin
        if (fin_juego) begin
          estado_d = FIN;
          cubos_d  = '0;
        end else if (!pausa) begin
          estado_d = ESPERA;
        end
      end
      FIN: begin
        // Restart keeps the LFSR running so successive games differ.
        if (!fin_juego && iniciar) begin
          estado_d   = ESPERA;
          periodo_d  = PER_INI;
          contador_d = PER_INI;
          cuenta_d   = 8'd0;
          nivel_d    = 3'd0;
        end
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase

    pulso_d   = (estado_d == EMITE);
    bandera_d = (estado_d == ESPERA) || (estado_d == EMITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= REPOSO;
      contador_q <= PER_INI;
      periodo_q  <= PER_INI;
      cuenta_q   <= 8'd0;
      nivel_q    <= 3'd0;
      cubos_q    <= '0;
      pulso_q    <= 1'b0;
      bandera_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      periodo_q  <= periodo_d;
      cuenta_q   <= cuenta_d;
      nivel_q    <= nivel_d;
      cubos_q    <= cubos_d;
      pulso_q    <= pulso_d;
      bandera_q  <= bandera_d;
    end
  end

  assign cubos_entrada           = cubos_q;
  assign pulso_habilitador       = pulso_q;
  assign bandera_habilitar_cubos = bandera_q;
  assign nivel                   = nivel_q;

endmodule

// File: tb/tb_planificador_cubos.sv
// Testbench for planificador_cubos: three instances share the same controls
// and differ only in seed, so special-pattern substitution is exercised on
// the very first spawn. A game-level reference model predicts every output.
module tb_planificador_cubos;
  import planificador_cubos_pkg::*;

  localparam int PI   = 4;
  localparam int PM   = 2;
  localparam int PASO = 1;
  localparam int CPN  = 2;
  localparam logic [15:0] SEM_A = 16'hACE1;
  localparam logic [15:0] SEM_B = 16'hACE0;  // low bits 00000
  localparam logic [15:0] SEM_C = 16'h001F;  // low bits 11111

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_frame = 1'b0;
  logic iniciar = 1'b0;
  logic pausa = 1'b0;
  logic fin_juego = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] cubos_a, cubos_b, cubos_c;
  logic       pulso_a, pulso_b, pulso_c;
  logic       bandera_a, bandera_b, bandera_c;
  logic [2:0] nivel_a, nivel_b, nivel_c;

  planificador_cubos #(.PERIODO_INICIAL(PI), .PERIODO_MINIMO(PM), .PASO_PERIODO(PASO),
                       .CUBOS_POR_NIVEL(CPN), .SEMILLA(SEM_A)) dut (
    .clk(clk), .reset(reset), .tick_frame(tick_frame), .iniciar(iniciar),
    .pausa(pausa), .fin_juego(fin_juego), .cubos_entrada(cubos_a),
    .pulso_habilitador(pulso_a), .bandera_habilitar_cubos(bandera_a), .nivel(nivel_a));

  planificador_cubos #(.PERIODO_INICIAL(PI), .PERIODO_MINIMO(PM), .PASO_PERIODO(PASO),
                       .CUBOS_POR_NIVEL(CPN), .SEMILLA(SEM_B)) dut_b (
    .clk(clk), .reset(reset), .tick_frame(tick_frame), .iniciar(iniciar),
    .pausa(pausa), .fin_juego(fin_juego), .cubos_entrada(cubos_b),
    .pulso_habilitador(pulso_b), .bandera_habilitar_cubos(bandera_b), .nivel(nivel_b));

  planificador_cubos #(.PERIODO_INICIAL(PI), .PERIODO_MINIMO(PM), .PASO_PERIODO(PASO),
                       .CUBOS_POR_NIVEL(CPN), .SEMILLA(SEM_C)) dut_c (
    .clk(clk), .reset(reset), .tick_frame(tick_frame), .iniciar(iniciar),
    .pausa(pausa), .fin_juego(fin_juego), .cubos_entrada(cubos_c),
    .pulso_habilitador(pulso_c), .bandera_habilitar_cubos(bandera_c), .nivel(nivel_c));

  int total = 0;
  int bad   = 0;

  // reference model: game-level view
  bit          m_jugando, m_en_pausa, m_emitiendo, m_terminado;
  int          m_restantes, m_periodo, m_spawns, m_nivel;
  logic [15:0] m_lfsr[3];
  logic [4:0]  m_cubos[3];

  function automatic logic [15:0] lfsr_sig(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [4:0] patron_ref(input logic [4:0] v);
    if (v == 5'd0)  return 5'd4;
    if (v == 5'd31) return 5'd27;
    return v;
  endfunction

  task automatic modelo_reset();
    m_jugando = 0; m_en_pausa = 0; m_emitiendo = 0; m_terminado = 0;
    m_periodo = PI; m_restantes = PI; m_spawns = 0; m_nivel = 0;
    m_lfsr[0] = SEM_A; m_lfsr[1] = SEM_B; m_lfsr[2] = SEM_C;
    for (int k = 0; k < 3; k++) m_cubos[k] = 5'd0;
  endtask

  task automatic modelo_terminar();
    m_terminado = 1; m_jugando = 0; m_en_pausa = 0;
    for (int k = 0; k < 3; k++) m_cubos[k] = 5'd0;
  endtask

  task automatic modelo_flanco(input bit t, input bit i, input bit p, input bit f);
    if (m_emitiendo) begin
      m_emitiendo = 0;
      m_spawns++;
      if (m_spawns == CPN) begin
        m_spawns  = 0;
        m_nivel   = (m_nivel < 7) ? m_nivel + 1 : 7;
        m_periodo = (m_periodo - PASO < PM) ? PM : m_periodo - PASO;
      end
      m_restantes = m_periodo;
    end else if (m_terminado) begin
      if (!f && i) begin
        m_terminado = 0; m_jugando = 1;
        m_periodo = PI; m_restantes = PI; m_nivel = 0; m_spawns = 0;
      end
    end else if (!m_jugando) begin
      if (i) begin
        m_jugando = 1;
        m_restantes = m_periodo;
      end
    end else if (m_en_pausa) begin
      if (f) modelo_terminar();
      else if (!p) m_en_pausa = 0;
    end else begin
      if (f) modelo_terminar();
      else if (p) m_en_pausa = 1;
      else if (t) begin
        if (m_restantes == 1) begin
          m_emitiendo = 1;
          for (int k = 0; k < 3; k++) begin
            m_cubos[k] = patron_ref(m_lfsr[k][4:0]);
            m_lfsr[k]  = lfsr_sig(m_lfsr[k]);
          end
        end else begin
          m_restantes--;
        end
      end
    end
  endtask

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic comparar_salidas();
    chequear("pulso",   pulso_a,   m_emitiendo);
    chequear("bandera", bandera_a, m_jugando && !m_en_pausa);
    chequear("nivel",   nivel_a,   m_nivel[2:0]);
    chequear("cubos_a", cubos_a,   m_cubos[0]);
    chequear("cubos_b", cubos_b,   m_cubos[1]);
    chequear("cubos_c", cubos_c,   m_cubos[2]);
  endtask

  // driver tasks
  task automatic ciclo(input bit t, input bit i, input bit p, input bit f);
    tick_frame = t; iniciar = i; pausa = p; fin_juego = f;
    @(posedge clk);
    modelo_flanco(t, i, p, f);
    #1;
    comparar_salidas();
  endtask

  task automatic ciclo_reset();
    reset = 1'b1; tick_frame = 0; iniciar = 0; pausa = 0; fin_juego = 0;
    @(posedge clk);
    modelo_reset();
    #1;
    comparar_salidas();
    reset = 1'b0;
  endtask

  task automatic tick_espaciado(input bit p);
    repeat (9) ciclo(0, 0, p, 0);
    ciclo(1, 0, p, 0);
  endtask

  initial begin
    modelo_reset();

    // reset state
    ciclo_reset();
    ciclo_reset();
    chequear("estado_reset", dut.estado_q, REPOSO);
    chequear("lfsr_reset",   dut.lfsr_valor, 16'hACE1);

    // start: first spawn one cycle after the 4th tick
    ciclo(0, 1, 0, 0);
    chequear("bandera_inicio", bandera_a, 1);
    repeat (4) tick_espaciado(0);
    chequear("pulso_tick4",  pulso_a, 1);
    chequear("cubos_rango",  (cubos_a != 5'd0) && (cubos_a != 5'd31), 1);
    chequear("patron_vacio", cubos_b, 5'b00100);
    chequear("patron_lleno", cubos_c, 5'b11011);
    chequear("nivel_0",      nivel_a, 0);

    // second spawn -> level 1, period 3
    repeat (4) tick_espaciado(0);
    chequear("pulso_spawn2", pulso_a, 1);
    ciclo(0, 0, 0, 0);
    chequear("nivel_1", nivel_a, 1);
    repeat (2) tick_espaciado(0);
    chequear("sin_pulso_2ticks", pulso_a, 0);
    tick_espaciado(0);
    chequear("pulso_periodo3", pulso_a, 1);

    // run on until the level saturates; the period floors at 2
    repeat (60) tick_espaciado(0);
    ciclo(0, 0, 0, 0);
    chequear("nivel_saturado", nivel_a, 7);

    // game over beats pause and tick in the same cycle
    ciclo(1, 0, 1, 1);
    chequear("fin_bandera", bandera_a, 0);
    chequear("fin_pulso",   pulso_a, 0);
    chequear("fin_cubos",   cubos_a, 0);
    chequear("fin_estado",  dut.estado_q, FIN);
    ciclo(0, 1, 0, 0);
    chequear("reinicio_nivel", nivel_a, 0);

    // pause after 2 ticks, 5 ticks ignored, then 2 more ticks to spawn
    repeat (2) tick_espaciado(0);
    repeat (5) tick_espaciado(1);
    chequear("pausa_bandera", bandera_a, 0);
    ciclo(0, 0, 0, 0);
    chequear("pausa_liberada", bandera_a, 1);
    tick_espaciado(0);
    chequear("tras_pausa_sin_pulso", pulso_a, 0);
    tick_espaciado(0);
    chequear("tras_pausa_pulso", pulso_a, 1);

    // randomized play
    for (int n = 0; n < 3000; n++) begin
      ciclo($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end

    // reset during an emission
    for (int k = 0; k < 200 && !m_emitiendo; k++) ciclo(1, 1, 0, 0);
    chequear("llega_emite", m_emitiendo, 1);
    chequear("pulso_antes_reset", pulso_a, 1);
    ciclo_reset();
    chequear("reset_pulso",   pulso_a, 0);
    chequear("reset_bandera", bandera_a, 0);
    chequear("reset_cubos",   cubos_a, 0);
    chequear("reset_nivel",   nivel_a, 0);
    chequear("reset_estado",  dut.estado_q, REPOSO);
    chequear("reset_lfsr",    dut.lfsr_valor, 16'hACE1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
